// File: rtl/ct_mem_arbiter.sv
// ct_mem_arbiter: lock-until-release arbiter for the single-port ciphertext buffer.
// Requesters: 0 = ciphertext-generation controller, 1 = GF(2^m)[z] multiplier,
// 2 = readout/unmasking stage.
//
// Ports:
//   clk, rst_b       clock, synchronous active-high reset
//   req[2:0]         ownership request, held for the whole transaction
//   gnt[2:0]         registered one-hot-or-zero grant
//   en/we[2:0]       per-requester access strobe / write enable
//   addr, wdata      packed per-requester buses, slice k at [k*W +: W]
//   rdata, rvalid    broadcast read data, per-requester read-valid strobe
//   mem_addr/di/we   memory drive, mem_do memory read data
//   err              sticky flag, set when a non-owner asserts en
//
// Build option: define CT_ARB_RR_EN for round-robin arbitration.
// Without it, fixed priority 0 > 1 > 2 is used.

module ct_mem_arbiter #(
    parameter int DW = 64,
    parameter int AW = 6
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [2:0]      req,
    output logic [2:0]      gnt,
    input  logic [2:0]      en,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    output logic [DW-1:0]   rdata,
    output logic [2:0]      rvalid,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_di,
    output logic            mem_we,
    input  logic [DW-1:0]   mem_do,
    output logic            err
);

    typedef enum logic [1:0] {
        OWN0 = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2,
        IDLE = 2'd3
    } owner_t;

    owner_t     owner_q;
    owner_t     owner_d;
    owner_t     win;
    logic [2:0] gnt_q;
    logic [2:0] cand;
    logic       hold;
    logic [2:0] rd_pend_q;
    logic       err_q;

    function automatic logic [2:0] onehot(input owner_t o);
        logic [2:0] g;
        g = 3'b000;
        unique case (o)
            OWN0:    g = 3'b001;
            OWN1:    g = 3'b010;
            OWN2:    g = 3'b100;
            default: g = 3'b000;
        endcase
        return g;
    endfunction

`ifdef CT_ARB_RR_EN
    logic [1:0] last_q;

    // Search starts one past the previous winner and wraps modulo 3.
    function automatic owner_t rr_pick(input logic [2:0] c,
                                       input logic [1:0] l);
        owner_t w;
        w = IDLE;
        unique case (l)
            2'd0: begin
                if (c[1])      w = OWN1;
                else if (c[2]) w = OWN2;
                else if (c[0]) w = OWN0;
            end
            2'd1: begin
                if (c[2])      w = OWN2;
                else if (c[0]) w = OWN0;
                else if (c[1]) w = OWN1;
            end
            default: begin
                if (c[0])      w = OWN0;
                else if (c[1]) w = OWN1;
                else if (c[2]) w = OWN2;
            end
        endcase
        return w;
    endfunction

    always_comb begin
        win = rr_pick(cand, last_q);
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            last_q <= 2'd2;
        end else if (owner_d != IDLE) begin
            last_q <= owner_d;
        end
    end
`else
    function automatic owner_t fp_pick(input logic [2:0] c);
        owner_t w;
        w = IDLE;
        if (c[0])      w = OWN0;
        else if (c[1]) w = OWN1;
        else if (c[2]) w = OWN2;
        return w;
    endfunction

    always_comb begin
        win = fp_pick(cand);
    end
`endif

    // The current owner is excluded from re-arbitration on release, so a
    // handover never re-grants the requester that just let go.
    always_comb begin
        cand    = req & ~gnt_q;
        hold    = |(req & gnt_q);
        owner_d = owner_q;
        if (!hold) begin
            owner_d = win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            owner_q   <= IDLE;
            gnt_q     <= 3'b000;
            rd_pend_q <= 3'b000;
            err_q     <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            gnt_q     <= onehot(owner_d);
            rd_pend_q <= gnt_q & en & ~we;
            if (|(en & ~gnt_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Only the owner's slice reaches the memory; IDLE drives zeros.
    always_comb begin
        mem_addr = '0;
        mem_di   = '0;
        unique case (owner_q)
            OWN0: begin
                mem_addr = addr[0*AW +: AW];
                mem_di   = wdata[0*DW +: DW];
            end
            OWN1: begin
                mem_addr = addr[1*AW +: AW];
                mem_di   = wdata[1*DW +: DW];
            end
            OWN2: begin
                mem_addr = addr[2*AW +: AW];
                mem_di   = wdata[2*DW +: DW];
            end
            default: ;
        endcase
    end

    assign mem_we = |(gnt_q & en & we);
    assign gnt    = gnt_q;
    assign rvalid = rd_pend_q;
    assign rdata  = mem_do;
    assign err    = err_q;

endmodule

// File: doc/ct_mem_arbiter.md
# ct_mem_arbiter

Three-way arbiter for the single-port ciphertext buffer (`mem_sp`, WIDTH = `M*`DIGIT`). Grants the port to one of:

- the ciphertext-generation controller (requester 0),
- the GF(2^m)[z] multiplier (requester 1),
- the output readout/unmasking stage (requester 2).

It replaces OR-combined address, data and write-enable buses with registered, lock-until-release ownership. It muxes the owner's access onto the memory, gates all non-owners, and returns a per-requester read-valid strobe aligned to the memory's one-cycle read latency.

## Interface

Parameters:

- DW, 64: data width, set to `M*`DIGIT` at instantiation.
- AW, 6: address width, set to `CLOG2(ceil(N/DIGIT))`.

Ports:

- clk  in  1  sole clock; all state updates on rising edge.
- rst_b  in  1  synchronous, active-high reset.
- req  in  3  per-requester ownership request, held high for the whole transaction.
- gnt  out  3  one-hot-or-zero grant, registered.
- en  in  3  per-requester access strobe, valid only while granted.
- we  in  3  per-requester write enable, qualified by en.
- addr  in  3*AW  requester addresses; requester k uses bits [k*AW +: AW].
- wdata  in  3*DW  requester write data, same packing as addr.
- rdata  out  DW  memory read data, broadcast to all requesters.
- rvalid  out  3  high the cycle rdata holds the result of requester k's read.
- mem_addr  out  AW  to memory addr.
- mem_di  out  DW  to memory di.
- mem_we  out  1  to memory we.
- mem_do  in  DW  from memory do.
- err  out  1  sticky protocol-violation flag.

## Operation

- State:
  - `owner`: 2 bits, values 0–2, or 3 meaning IDLE.
  - `rd_pend`: 3 bits.
  - `err`: 1 bit.
  - `last`: 2 bits, round-robin pointer; present only with the macro defined.
- gnt[k] = (owner == k). All-zero gnt means IDLE.
- Transitions are evaluated each edge:
  - IDLE with any req high: owner becomes the winner.
  - IDLE with no req: stay IDLE.
  - owner k with req[k] high: stay k. Lock is held; other requests are ignored, no preemption.
  - owner k with req[k] low: re-arbitrate among the current req, excluding k. If none qualifies, go IDLE. Handover is back-to-back with no idle cycle.
- Arbitration policy:
  - Without the macro: fixed priority 0 > 1 > 2.
  - With the macro: see Configuration.
- Memory drive:
  - mem_addr and mem_di carry the owner's addr and wdata slice.
  - mem_we = we[owner] & en[owner].
  - In IDLE: mem_addr = 0, mem_di = 0, mem_we = 0.
- Signal gating:
  - en and we of non-owners never reach the memory.
  - A non-owner asserting en sets err. err clears only on reset.
  - A non-owner asserting we without en is ignored and does not set err.
- Read return:
  - rd_pend[k] <= gnt[k] & en[k] & ~we[k].
  - rvalid = rd_pend. rdata = mem_do, passed through without a register.
- A read issued in the owner's final cycle (the cycle req drops) still returns rvalid one cycle later, even though the grant has moved.

## Timing

- Reset values:
  - gnt = 0, rvalid = 0, err = 0.
  - mem_we = 0, mem_addr = 0, mem_di = 0.
  - owner = IDLE, last = 2, so requester 0 is first under round-robin.
- Grant latency: req rising at edge t (sampled) gives gnt at t+1. The requester may assert en in the same cycle it sees gnt.
- Release: req low sampled at edge t gives gnt low at t+1. The next winner's gnt rises at t+1.
- Read latency: en & ~we in cycle c gives rvalid and valid rdata in cycle c+1.
- Write: takes effect at the edge ending the cycle with mem_we high.
- Simultaneous requests in IDLE: exactly one grant, chosen by policy.
- Reset asserted mid-transaction:
  - Next cycle, all state is at reset values.
  - In-flight rvalid is dropped.
  - Requesters must re-request.
- Requester holding req indefinitely: starves the others. This is by design; the controllers bound their own tenure.

## Configuration

- `CT_ARB_RR_EN` defined:
  - Round-robin arbitration. The search starts at (last+1) mod 3.
  - last <= the new owner on every grant.
- `CT_ARB_RR_EN` undefined:
  - Fixed priority 0 > 1 > 2.
  - The `last` register is not built.

## Test plan

- Reset, then req = 3'b010 at cycle 2: gnt = 3'b010 at cycle 3. en[1] = 1, we[1] = 0, addr1 = 5: rvalid = 3'b010 next cycle with rdata = mem[5].
- req = 3'b111 from IDLE:
  - Without the macro: gnt sequence 001, 010, 100 as each owner drops req after 4 cycles, with no gap cycles.
  - With the macro: same sequence, then a repeated req=111 grants 001 again after 100.
- Owner 0 writes 0xA5 to addr 3 while requester 2 asserts en[2] = 1 and we[2] = 1 to addr 3: mem_we follows requester 0 only, memory holds 0xA5 at addr 3, and err = 1 one cycle later and stays high.
- Owner 1 issues a read on the cycle it drops req while req[2] = 1: gnt = 100 next cycle, and rvalid = 010 in that same cycle.
- Reset pulsed during an owner-2 read burst: the cycle after reset, gnt = 0, rvalid = 0 and mem_we = 0. After release, req = 100 is granted again within 1 cycle.
- Round-robin build, requesters 0 and 1 continuously re-requesting with 1-cycle tenure: gnt alternates 001/010. Fixed-priority build with the same stimulus: 001 wins on every arbitration in which req[0] is high.
